// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO between ifetch and id, with optional bypass.
// Ports: enq_* from fetch, deq_* to decode, flush_i, count_o/full_o/empty_o.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enq_valid_i,
  input  logic [PC_W-1:0]          enq_pc_i,
  input  logic [INST_W-1:0]        enq_inst_i,
  output logic                     enq_ready_o,
  output logic                     deq_valid_o,
  output logic [PC_W-1:0]          deq_pc_o,
  output logic [INST_W-1:0]        deq_inst_o,
  input  logic                     deq_ready_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic enq_fire;
  logic deq_fire;
  logic do_push;
  logic do_pop;
  logic pass_thru;

  assign count_o     = count;
  assign full_o      = (count == CW'(DEPTH));
  assign empty_o     = (count == '0);
  assign enq_ready_o = !full_o;

  // Bypass presents the incoming word while empty; flush suppresses it.
  always_comb begin
    pass_thru   = 1'b0;
    deq_valid_o = !empty_o;
    if (BYPASS) begin
      pass_thru   = empty_o && enq_valid_i && !flush_i;
      deq_valid_o = !flush_i && (!empty_o || enq_valid_i);
    end
  end

  always_comb begin
    deq_pc_o   = '0;
    deq_inst_o = '0;
    if (deq_valid_o) begin
      if (pass_thru) begin
        deq_pc_o   = enq_pc_i;
        deq_inst_o = enq_inst_i;
      end else begin
        deq_pc_o   = pc_mem[rd_ptr];
        deq_inst_o = inst_mem[rd_ptr];
      end
    end
  end

  assign enq_fire = enq_valid_i && enq_ready_o;
  assign deq_fire = deq_valid_o && deq_ready_i;
  // A bypassed word consumed this cycle never touches storage.
  assign do_push  = enq_fire && !(pass_thru && deq_ready_i);
  assign do_pop   = deq_fire && !empty_o;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset && !flush_i && do_push) begin
      pc_mem[wr_ptr]   <= enq_pc_i;
      inst_mem[wr_ptr] <= enq_inst_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue, BYPASS=0 and BYPASS=1.
// Two instances share clock and reset; each has its own handshake inputs.
module tb_fetch_queue;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int vec  = 0;
  int errs = 0;

  // BYPASS=0 instance
  logic        a_ev = 0, a_dr = 0, a_fl = 0;
  logic [63:0] a_epc = '0;
  logic [31:0] a_ein = '0;
  logic        a_er, a_dv, a_full, a_empty;
  logic [63:0] a_dpc;
  logic [31:0] a_din;
  logic [2:0]  a_cnt;

  // BYPASS=1 instance
  logic        b_ev = 0, b_dr = 0, b_fl = 0;
  logic [63:0] b_epc = '0;
  logic [31:0] b_ein = '0;
  logic        b_er, b_dv, b_full, b_empty;
  logic [63:0] b_dpc;
  logic [31:0] b_din;
  logic [2:0]  b_cnt;

  fetch_queue #(.DEPTH(4), .PC_W(64), .INST_W(32), .BYPASS(1'b0)) u_a (
    .clock(clock), .reset(reset),
    .enq_valid_i(a_ev), .enq_pc_i(a_epc), .enq_inst_i(a_ein),
    .enq_ready_o(a_er), .deq_valid_o(a_dv), .deq_pc_o(a_dpc),
    .deq_inst_o(a_din), .deq_ready_i(a_dr), .flush_i(a_fl),
    .count_o(a_cnt), .full_o(a_full), .empty_o(a_empty)
  );

  fetch_queue #(.DEPTH(4), .PC_W(64), .INST_W(32), .BYPASS(1'b1)) u_b (
    .clock(clock), .reset(reset),
    .enq_valid_i(b_ev), .enq_pc_i(b_epc), .enq_inst_i(b_ein),
    .enq_ready_o(b_er), .deq_valid_o(b_dv), .deq_pc_o(b_dpc),
    .deq_inst_o(b_din), .deq_ready_i(b_dr), .flush_i(b_fl),
    .count_o(b_cnt), .full_o(b_full), .empty_o(b_empty)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    vec++; if (a_cnt !== 3'd0) begin errs++; $display("FAIL rst_count got %0d want 0", a_cnt); end
    vec++; if (a_empty !== 1'b1) begin errs++; $display("FAIL rst_empty got %b want 1", a_empty); end
    vec++; if (a_full !== 1'b0) begin errs++; $display("FAIL rst_full got %b want 0", a_full); end
    vec++; if (a_er !== 1'b1) begin errs++; $display("FAIL rst_enq_ready got %b want 1", a_er); end
    vec++; if (a_dv !== 1'b0) begin errs++; $display("FAIL rst_deq_valid got %b want 0", a_dv); end
    vec++; if (a_dpc !== 64'h0) begin errs++; $display("FAIL rst_deq_pc got %h want 0", a_dpc); end
  endtask

  task automatic test_fill();
    a_dr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_ev  = 1'b1;
      a_epc = 64'h1000 + 64'(4 * k);
      a_ein = 32'h13 + 32'(k);
      tick();
    end
    a_epc = 64'h1010;
    a_ein = 32'h17;
    #1;
    vec++; if (a_full !== 1'b1) begin errs++; $display("FAIL fill_full got %b want 1", a_full); end
    vec++; if (a_cnt !== 3'd4) begin errs++; $display("FAIL fill_count got %0d want 4", a_cnt); end
    vec++; if (a_er !== 1'b0) begin errs++; $display("FAIL fill_enq_ready got %b want 0", a_er); end
    tick();
    a_ev = 1'b0;
    #1;
    vec++; if (a_cnt !== 3'd4) begin errs++; $display("FAIL fill_5th_count got %0d want 4", a_cnt); end
    vec++; if (a_dpc !== 64'h1000) begin errs++; $display("FAIL fill_head got %h want 1000", a_dpc); end
  endtask

  task automatic test_drain();
    logic [63:0] epc;
    logic [31:0] ein;
    a_dr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      epc = 64'h1000 + 64'(4 * k);
      ein = 32'h13 + 32'(k);
      #1;
      vec++; if (a_dv !== 1'b1) begin errs++; $display("FAIL drain_valid[%0d] got %b want 1", k, a_dv); end
      vec++; if (a_dpc !== epc) begin errs++; $display("FAIL drain_pc[%0d] got %h want %h", k, a_dpc, epc); end
      vec++; if (a_din !== ein) begin errs++; $display("FAIL drain_inst[%0d] got %h want %h", k, a_din, ein); end
      tick();
    end
    #1;
    vec++; if (a_dv !== 1'b0) begin errs++; $display("FAIL drain_end_valid got %b want 0", a_dv); end
    vec++; if (a_dpc !== 64'h0) begin errs++; $display("FAIL drain_end_pc got %h want 0", a_dpc); end
    vec++; if (a_empty !== 1'b1) begin errs++; $display("FAIL drain_end_empty got %b want 1", a_empty); end
    // Dequeue request on an empty queue must be ignored.
    tick();
    vec++; if (a_cnt !== 3'd0) begin errs++; $display("FAIL empty_pop_count got %0d want 0", a_cnt); end
    a_dr = 1'b0;
  endtask

  task automatic test_stream();
    logic [63:0] epc;
    a_ev = 1'b1; a_epc = 64'h4000; a_ein = 32'h40; tick();
    a_epc = 64'h4004; a_ein = 32'h41; tick();
    a_dr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_epc = 64'h4000 + 64'(4 * (i + 2));
      a_ein = 32'h40 + 32'(i + 2);
      epc   = 64'h4000 + 64'(4 * i);
      #1;
      vec++; if (a_dpc !== epc) begin errs++; $display("FAIL stream_pc[%0d] got %h want %h", i, a_dpc, epc); end
      tick();
      vec++; if (a_cnt !== 3'd2) begin errs++; $display("FAIL stream_count[%0d] got %0d want 2", i, a_cnt); end
    end
    a_dr = 1'b0;
    a_epc = 64'h4030; a_ein = 32'h4c;
    tick();
    a_ev = 1'b0;
    #1;
    vec++; if (a_cnt !== 3'd3) begin errs++; $display("FAIL stream_count3 got %0d want 3", a_cnt); end
    vec++; if (a_dpc !== 64'h4028) begin errs++; $display("FAIL stream_head got %h want 4028", a_dpc); end
  endtask

  task automatic test_flush();
    a_fl = 1'b1;
    a_ev = 1'b1; a_epc = 64'h2000; a_ein = 32'h20;
    tick();
    a_fl = 1'b0;
    a_ev = 1'b0;
    #1;
    vec++; if (a_cnt !== 3'd0) begin errs++; $display("FAIL flush_count got %0d want 0", a_cnt); end
    vec++; if (a_dv !== 1'b0) begin errs++; $display("FAIL flush_valid got %b want 0", a_dv); end
    a_dr = 1'b1;
    tick();
    vec++; if (a_dpc === 64'h2000) begin errs++; $display("FAIL flush_leak got %h want not 2000", a_dpc); end
    vec++; if (a_empty !== 1'b1) begin errs++; $display("FAIL flush_empty got %b want 1", a_empty); end
    a_dr = 1'b0;
  endtask

  task automatic test_bypass();
    b_ev = 1'b1; b_epc = 64'h3000; b_ein = 32'h00A00513; b_dr = 1'b1;
    #1;
    vec++; if (b_dv !== 1'b1) begin errs++; $display("FAIL byp_valid got %b want 1", b_dv); end
    vec++; if (b_dpc !== 64'h3000) begin errs++; $display("FAIL byp_pc got %h want 3000", b_dpc); end
    vec++; if (b_din !== 32'h00A00513) begin errs++; $display("FAIL byp_inst got %h want 00a00513", b_din); end
    tick();
    b_ev = 1'b0;
    #1;
    vec++; if (b_cnt !== 3'd0) begin errs++; $display("FAIL byp_consumed_count got %0d want 0", b_cnt); end
    b_ev = 1'b1; b_dr = 1'b0;
    #1;
    vec++; if (b_dpc !== 64'h3000) begin errs++; $display("FAIL byp2_pc got %h want 3000", b_dpc); end
    tick();
    b_ev = 1'b0;
    #1;
    vec++; if (b_cnt !== 3'd1) begin errs++; $display("FAIL byp_stored_count got %0d want 1", b_cnt); end
    vec++; if (b_dpc !== 64'h3000) begin errs++; $display("FAIL byp_stored_head got %h want 3000", b_dpc); end
    vec++; if (b_dv !== 1'b1) begin errs++; $display("FAIL byp_stored_valid got %b want 1", b_dv); end
    b_fl = 1'b1;
    #1;
    vec++; if (b_dv !== 1'b0) begin errs++; $display("FAIL byp_flush_valid got %b want 0", b_dv); end
    tick();
    b_fl = 1'b0;
    #1;
    vec++; if (b_cnt !== 3'd0) begin errs++; $display("FAIL byp_flush_count got %0d want 0", b_cnt); end
  endtask

  task automatic test_reset_mid();
    a_ev = 1'b1; a_epc = 64'h5000; a_ein = 32'h50; tick();
    a_epc = 64'h5004; a_ein = 32'h51; tick();
    #1;
    vec++; if (a_cnt !== 3'd2) begin errs++; $display("FAIL mid_pre_count got %0d want 2", a_cnt); end
    a_epc = 64'h5008; a_ein = 32'h52;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    a_ev = 1'b0;
    #1;
    vec++; if (a_cnt !== 3'd0) begin errs++; $display("FAIL mid_count got %0d want 0", a_cnt); end
    vec++; if (a_empty !== 1'b1) begin errs++; $display("FAIL mid_empty got %b want 1", a_empty); end
    vec++; if (a_dv !== 1'b0) begin errs++; $display("FAIL mid_valid got %b want 0", a_dv); end
    vec++; if (a_dpc !== 64'h0) begin errs++; $display("FAIL mid_pc got %h want 0", a_dpc); end
    vec++; if (a_din !== 32'h0) begin errs++; $display("FAIL mid_inst got %h want 0", a_din); end
    vec++; if (a_er !== 1'b1) begin errs++; $display("FAIL mid_enq_ready got %b want 1", a_er); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction fetch queue that decouples the fetch stage from the decode stage. It generalises the single-entry fetch/decode pipeline register into a DEPTH-entry FIFO.
- Adds an optional same-cycle bypass mode, occupancy reporting, and a branch-redirect flush that discards all queued instructions.
- Sits between ifetch and id. The control unit's stall becomes backpressure via deq_ready_i.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PC_W, 64, pc width.
- INST_W, 32, instruction width.
- BYPASS, 0, 1 = an empty queue forwards enq to deq combinationally in the same cycle; 0 = minimum latency is 1 cycle.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 at posedge clears all state).
- enq_valid_i  in  1  fetch presents an instruction.
- enq_pc_i  in  PC_W  pc of the presented instruction.
- enq_inst_i  in  INST_W  presented instruction word.
- enq_ready_o  out  1  queue accepts this cycle.
- deq_valid_o  out  1  head entry (or bypassed entry) valid.
- deq_pc_o  out  PC_W  head pc.
- deq_inst_o  out  INST_W  head instruction.
- deq_ready_i  in  1  decode consumes the head this cycle.
- flush_i  in  1  branch redirect: discard all contents.
- count_o  out  log2(DEPTH)+1  current occupancy.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.

Behaviour:
- Storage and pointers:
  - Storage is DEPTH entries of {pc, inst}.
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The count register is log2(DEPTH)+1 bits.
- Handshake:
  - Enqueue fires when enq_valid_i && enq_ready_o.
  - Dequeue fires when deq_valid_o && deq_ready_i.
  - enq_ready_o = !full_o. It has no combinational dependence on deq_ready_i, so a full queue rejects enqueue even when a dequeue fires in the same cycle.
- Output qualification:
  - deq_pc_o and deq_inst_o are driven to 0 whenever deq_valid_o = 0.
  - With BYPASS=0, deq_valid_o = !empty_o and the outputs come from storage at the read pointer; this path is combinational from registers only.
- BYPASS=1 mode:
  - When empty_o && enq_valid_i && !flush_i: deq_valid_o = 1 and the deq outputs equal the enq inputs.
  - If deq_ready_i is also 1, the entry is consumed without being written and count stays 0.
  - Otherwise the entry is written and count becomes 1.
- Simultaneous enqueue and dequeue, not full: both pointers advance and count is unchanged.
- Flush:
  - flush_i = 1 at posedge sets both pointers and count to 0; a same-cycle enqueue is dropped.
  - Flush has priority over enqueue and dequeue.
  - With BYPASS=1, flush_i also forces deq_valid_o = 0 combinationally.
- Reset (reset = 0 at posedge):
  - Pointers and count go to 0, so deq_valid_o = 0, deq_pc_o/deq_inst_o = 0, enq_ready_o = 1, empty_o = 1, full_o = 0.
  - Reset takes priority over flush and handshakes and aborts any in-flight enqueue.
  - Storage contents need no reset.
- Ordering: strict FIFO order; no entry is duplicated or lost except by flush or reset.
- Protocol errors: behaviour when deq_ready_i = 1 while deq_valid_o = 0 is a no-op.
- Implementation notes:
  - Full and empty are derived from count, not pointer equality.
  - A DEPTH-1 wrap must not corrupt count.

Test Plan:
- Reset then fill, DEPTH=4, BYPASS=0, deq_ready_i=0, enq pc 0x1000..0x100C, insts 0x00000013+k: after 4 cycles full_o=1, count_o=4, enq_ready_o=0; a 5th enq of pc 0x1010 is not accepted.
- Drain the full queue with deq_ready_i=1: deq_pc_o sequence is 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles, then deq_valid_o=0, deq_pc_o=0, empty_o=1.
- Continuous enq and deq for 10 cycles at count=2: count_o stays 2, pointers wrap past 3 to 0, and output order matches input order with 2-cycle latency.
- Flush at count=3 with a simultaneous enq of pc 0x2000: next cycle count_o=0, deq_valid_o=0; pc 0x2000 never appears at deq.
- BYPASS=1, empty, enq pc 0x3000 inst 0x00A00513 with deq_ready_i=1: same cycle deq_valid_o=1, deq_pc_o=0x3000; next cycle count_o=0. Repeat with deq_ready_i=0: next cycle count_o=1 and the head is pc 0x3000.
- Reset driven low for 1 cycle at count=2 during an enqueue: next cycle count_o=0, empty_o=1, deq outputs 0, enq_ready_o=1.
